// File: rtl/sonar_responder.sv
// Ultrasonic ranging sensor emulator: answers a trig pulse with an echo
// pulse whose width encodes the configured target distance.
module sonar_responder #(
    parameter int CLK_PER_US  = 100,
    parameter int MIN_TRIG_US = 10,
    parameter int BURST_US    = 200,
    parameter int US_PER_CM   = 58,
    parameter int MAX_CM      = 400,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       trig,
    input  logic [8:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic [2:0] o_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG_HI = 3'd1;
    localparam logic [2:0] S_BURST   = 3'd2;
    localparam logic [2:0] S_ECHO    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    localparam int CW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int HMAX = MIN_TRIG_US * CLK_PER_US;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX + 1) : 1;

    localparam logic [CW-1:0] CYC_LAST   = CW'(CLK_PER_US - 1);
    localparam logic [HW-1:0] HI_MIN     = HW'(HMAX);
    localparam logic [15:0]   BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0]   HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]   CM_US      = 16'(US_PER_CM);
    localparam logic [15:0]   TO_US      = 16'(TIMEOUT_US);
    localparam logic [8:0]    MAX_D      = 9'(MAX_CM);

    logic          trig_m;
    logic          trig_s;
    logic          trig_d;
    logic [1:0]    fill;
    logic          armed;
    logic          rise;
    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic          err_nx;
    logic          latch;
    logic [CW-1:0] cyc;
    logic [15:0]   us_cnt;
    logic [HW-1:0] hi_cnt;
    logic [8:0]    dist_q;
    logic [15:0]   echo_len;
    logic [15:0]   limit;
    logic          tick;
    logic          done;

    // Synchronize trig; arm edge detection only once trig_s has been seen
    // low after reset, so a trig held high through reset release is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
            fill   <= 2'b00;
            armed  <= 1'b0;
        end else begin
            trig_m <= trig;
            trig_s <= trig_m;
            trig_d <= trig_s;
            if (fill != 2'b11)
                fill <= {fill[0], 1'b1};
            if (fill == 2'b11 && !trig_s)
                armed <= 1'b1;
        end
    end

    assign rise    = armed & trig_s & ~trig_d;
    assign busy    = (state != S_IDLE);
    assign o_state = state;

    // Echo length in us from the latched distance, plus the active timer limit.
    always_comb begin
        echo_len = TO_US;
        if (dist_q == 9'd0)
            echo_len = CM_US;
        else if (dist_q <= MAX_D)
            echo_len = 16'(dist_q) * CM_US;
        limit = 16'd0;
        case (state)
            S_BURST:   limit = BURST_LAST;
            S_ECHO:    limit = echo_len - 16'd1;
            S_HOLDOFF: limit = HOLD_LAST;
            default:   limit = 16'd0;
        endcase
    end

    assign tick = (cyc == CYC_LAST);
    assign done = tick && (us_cnt == limit);

    // Next-state logic; unused codes fall back to IDLE.
    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        latch    = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise && enable)
                    state_nx = S_TRIG_HI;
            end
            S_TRIG_HI: begin
                if (!trig_s) begin
                    if (hi_cnt >= HI_MIN) begin
                        state_nx = S_BURST;
                        latch    = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                        err_nx   = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (done)
                    state_nx = S_ECHO;
            end
            S_ECHO: begin
                if (done)
                    state_nx = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (done)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, registered outputs and latched distance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            trig_err <= 1'b0;
            echo     <= 1'b0;
            dist_q   <= 9'd0;
        end else begin
            state    <= state_nx;
            trig_err <= err_nx;
            echo     <= (state == S_ECHO);
            if (latch)
                dist_q <= distance_cm;
        end
    end

    // Cycle and us timers, cleared on every state entry and while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= '0;
            us_cnt <= 16'd0;
        end else if (state_nx != state || state == S_IDLE) begin
            cyc    <= '0;
            us_cnt <= 16'd0;
        end else if (tick) begin
            cyc    <= '0;
            us_cnt <= us_cnt + 16'd1;
        end else begin
            cyc    <= cyc + CW'(1);
        end
    end

    // Trig-high width, counting the rising-edge cycle, saturating at minimum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hi_cnt <= '0;
        else if (state == S_IDLE)
            hi_cnt <= HW'(1);
        else if (state == S_TRIG_HI && trig_s && hi_cnt < HI_MIN)
            hi_cnt <= hi_cnt + HW'(1);
    end

endmodule

// File: tb/tb_sonar_responder.sv
// Self-checking bench for sonar_responder with scaled-down timing parameters.
// Expected echo widths are queued at stimulus time and checked on echo fall.
module tb_sonar_responder;

    localparam int CPU  = 2;
    localparam int MINT = 3;
    localparam int BUS  = 5;
    localparam int UPC  = 3;
    localparam int MAXC = 400;
    localparam int TO   = 1500;
    localparam int HOLD = 20;
    localparam int BURST_CLK = BUS * CPU;
    localparam int HOLD_CLK  = HOLD * CPU;
    localparam int MIN_CLK   = MINT * CPU;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       trig = 1'b0;
    logic [8:0] distance_cm = 9'd0;
    logic       echo;
    logic       busy;
    logic       trig_err;
    logic [2:0] o_state;

    int total = 0;
    int bad = 0;
    int sb[$];
    int err_seen = 0;
    int ecnt = 0;
    int bcnt = 0;
    int hcnt = 0;
    logic prev_e = 1'b0;
    logic [2:0] prev_st = 3'd0;

    sonar_responder #(
        .CLK_PER_US(CPU), .MIN_TRIG_US(MINT), .BURST_US(BUS),
        .US_PER_CM(UPC), .MAX_CM(MAXC), .TIMEOUT_US(TO),
        .HOLDOFF_US(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .trig(trig),
        .distance_cm(distance_cm), .echo(echo), .busy(busy),
        .trig_err(trig_err), .o_state(o_state)
    );

    always #5 clk = ~clk;

    function automatic int exp_clocks(input int d);
        if (d == 0) return UPC * CPU;
        if (d <= MAXC) return d * UPC * CPU;
        return TO * CPU;
    endfunction

    // Monitor: echo width vs scoreboard, BURST and HOLDOFF durations.
    always @(negedge clk) begin
        if (reset) begin
            ecnt = 0; bcnt = 0; hcnt = 0;
            prev_e = 1'b0; prev_st = 3'd0;
        end else begin
            if (trig_err) err_seen++;
            if (echo) ecnt++;
            else if (prev_e) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL echo_unexpected got=%0d clocks", ecnt);
                end else begin
                    int e;
                    e = sb.pop_front();
                    if (ecnt !== e) begin
                        bad++;
                        $display("FAIL echo_width got=%0d want=%0d", ecnt, e);
                    end
                end
                ecnt = 0;
            end
            if (o_state == 3'd2) bcnt++;
            else if (prev_st == 3'd2) begin
                total++;
                if (bcnt !== BURST_CLK || o_state !== 3'd3) begin
                    bad++;
                    $display("FAIL burst_len got=%0d want=%0d next=%0d",
                             bcnt, BURST_CLK, o_state);
                end
                bcnt = 0;
            end
            if (o_state == 3'd4) hcnt++;
            else if (prev_st == 3'd4) begin
                total++;
                if (hcnt !== HOLD_CLK) begin
                    bad++;
                    $display("FAIL holdoff_len got=%0d want=%0d", hcnt, HOLD_CLK);
                end
                hcnt = 0;
            end
            prev_e = echo;
            prev_st = o_state;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input int w);
        trig = 1'b1;
        tick(w);
        trig = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input string nm);
        int n;
        n = 0;
        while (o_state !== st && n < 8000) begin
            tick(1);
            n++;
        end
        total++;
        if (o_state !== st) begin
            bad++;
            $display("FAIL %s timeout state=%0d want=%0d", nm, o_state, st);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(3);
        total += 4;
        if (echo !== 1'b0) begin bad++; $display("FAIL rst_echo got=%b want=0", echo); end
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        if (trig_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", trig_err); end
        if (o_state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", o_state); end
        reset = 1'b0;
        enable = 1'b1;
        tick(5);
    endtask

    task automatic test_short();
        int e0;
        e0 = err_seen;
        pulse(4);
        tick(8);
        total += 2;
        if (err_seen - e0 !== 1) begin
            bad++; $display("FAIL short_err got=%0d want=1", err_seen - e0);
        end
        if (o_state !== 3'd0) begin
            bad++; $display("FAIL short_idle got=%0d want=0", o_state);
        end
        e0 = err_seen;
        pulse(MIN_CLK - 1);
        tick(8);
        total++;
        if (err_seen - e0 !== 1) begin
            bad++; $display("FAIL edge_short_err got=%0d want=1", err_seen - e0);
        end
        e0 = err_seen;
        distance_cm = 9'd2;
        sb.push_back(exp_clocks(2));
        pulse(MIN_CLK);
        wait_state(3'd0, "edge_ok_idle");
        total++;
        if (err_seen - e0 !== 0) begin
            bad++; $display("FAIL edge_ok_err got=%0d want=0", err_seen - e0);
        end
    endtask

    task automatic test_distances();
        int ds[5] = '{10, 0, 400, 401, 511};
        foreach (ds[i]) begin
            distance_cm = 9'(ds[i]);
            sb.push_back(exp_clocks(ds[i]));
            pulse(8);
            wait_state(3'd2, "dist_burst");
            distance_cm = 9'($urandom_range(1, 511));
            wait_state(3'd0, "dist_idle");
            tick(2);
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        e0 = err_seen;
        distance_cm = 9'd20;
        sb.push_back(exp_clocks(20));
        pulse(8);
        wait_state(3'd3, "b2b_echo");
        tick(5);
        pulse(8);
        wait_state(3'd4, "b2b_hold");
        tick(2);
        pulse(8);
        wait_state(3'd0, "b2b_idle");
        total++;
        if (err_seen - e0 !== 0) begin
            bad++; $display("FAIL b2b_err got=%0d want=0", err_seen - e0);
        end
        tick(2);
        distance_cm = 9'd7;
        sb.push_back(exp_clocks(7));
        pulse(8);
        wait_state(3'd0, "b2b_next_idle");
        tick(2);
    endtask

    task automatic test_enable();
        logic seen;
        seen = 1'b0;
        enable = 1'b0;
        trig = 1'b1;
        repeat (8) begin tick(1); seen |= busy; end
        trig = 1'b0;
        repeat (12) begin tick(1); seen |= busy; end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL disabled_busy got=%b want=0", seen);
        end
        enable = 1'b1;
        distance_cm = 9'd4;
        sb.push_back(exp_clocks(4));
        pulse(8);
        wait_state(3'd2, "en_burst");
        enable = 1'b0;
        wait_state(3'd4, "en_hold");
        wait_state(3'd0, "en_idle");
        enable = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        distance_cm = 9'd200;
        sb.push_back(exp_clocks(200));
        pulse(8);
        wait_state(3'd3, "mid_echo");
        tick(20);
        trig = 1'b1;
        tick(3);
        #1 reset = 1'b1;
        #1;
        total += 2;
        if (echo !== 1'b0) begin bad++; $display("FAIL mid_rst_echo got=%b want=0", echo); end
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        void'(sb.pop_back());
        tick(3);
        reset = 1'b0;
        repeat (30) begin tick(1); seen |= busy; end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL held_trig_busy got=%b want=0", seen);
        end
        trig = 1'b0;
        tick(5);
        distance_cm = 9'd3;
        sb.push_back(exp_clocks(3));
        pulse(8);
        wait_state(3'd0, "mid_next_idle");
        tick(3);
    endtask

    initial begin
        test_reset();
        test_short();
        test_distances();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        total++;
        if (sb.size() !== 0) begin
            bad++; $display("FAIL sb_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sonar_responder.md
SONAR_RESPONDER -- requirements
Module: sonar_responder

Interface
REQ-001 SHALL provide parameters (name, default, meaning): CLK_PER_US, 100, clocks per microsecond.
REQ-002 SHALL provide parameters: MIN_TRIG_US, 10, minimum accepted trig width in us.
REQ-003 SHALL provide parameters: BURST_US, 200, delay from accepted trig fall to echo rise in us; US_PER_CM, 58, echo us per cm.
REQ-004 SHALL provide parameters: MAX_CM, 400, largest in-range distance; TIMEOUT_US, 38000, echo width when out of range; HOLDOFF_US, 10000, dead time after echo fall.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  high = respond to trig; low = ignore new trig pulses.
REQ-008 trig  input  1  trigger pulse from the sensor controller, asynchronous to clk.
REQ-009 distance_cm  input  9  emulated target distance in cm, sampled on accepted trig fall.
REQ-010 echo  output  1  registered echo pulse; width encodes distance.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 trig_err  output  1  one-cycle pulse when a trig pulse is rejected as too short.
REQ-013 o_state  output  3  current state encoding, for debug.

Function
REQ-014 trig SHALL pass through a 2-flop synchronizer; every edge detection SHALL use the synchronized value trig_s.
REQ-015 States and encodings SHALL be: IDLE=0, TRIG_HI=1, BURST=2, ECHO=3, HOLDOFF=4; codes 5-7 SHALL return to IDLE on the next cycle.
REQ-016 A clock-cycle counter SHALL clear on every state entry; an us counter SHALL increment once each time the clock-cycle counter reaches CLK_PER_US-1.
REQ-017 IDLE: on a trig_s rising edge with enable=1, the block SHALL go to TRIG_HI; a trig_s rise with enable=0 SHALL be ignored.
REQ-018 TRIG_HI: the block SHALL count clocks while trig_s=1, saturating at MIN_TRIG_US*CLK_PER_US.
REQ-019 On trig_s fall with count >= MIN_TRIG_US*CLK_PER_US: the block SHALL latch distance_cm and go to BURST.
REQ-020 On trig_s fall with count below MIN_TRIG_US*CLK_PER_US: the block SHALL pulse trig_err for one cycle and go to IDLE.
REQ-021 Echo length in us (16-bit arithmetic, no overflow) SHALL be selected as follows.
  - latched d=0: US_PER_CM
  - 1 <= d <= MAX_CM: d*US_PER_CM
  - d > MAX_CM: TIMEOUT_US
REQ-022 BURST SHALL last exactly BURST_US*CLK_PER_US clocks, then go to ECHO.
REQ-023 ECHO: echo SHALL be 1 for exactly echo_length*CLK_PER_US clocks, then go to HOLDOFF.
REQ-024 echo SHALL be 1 only in ECHO; it SHALL rise the cycle after ECHO is entered and fall the cycle after ECHO is left.
REQ-025 HOLDOFF SHALL last HOLDOFF_US*CLK_PER_US clocks, then go to IDLE.
REQ-026 trig activity in BURST, ECHO or HOLDOFF SHALL be ignored, with no trig_err.
REQ-027 A trig_s already high on return to IDLE SHALL NOT start a cycle; only a new rising edge does.
REQ-028 enable deasserted mid-cycle SHALL NOT abort the cycle; the block finishes through HOLDOFF.
REQ-029 distance_cm changes after latching SHALL NOT affect the current echo.

Reset
REQ-030 While reset=1: state=IDLE, echo=0, busy=0, trig_err=0, o_state=0, and all counters, synchronizer flops and the latched distance SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL drop echo within the same reset assertion and abandon the cycle.
REQ-032 After reset release, a trig already high SHALL be ignored until it falls and rises again.

Verification (CLK_PER_US=100, defaults)
REQ-033 enable=1, trig high 20 us, d=100 -> echo rises 20000 clocks after BURST entry and stays high exactly 580000 clocks.
REQ-034 trig high 5 us -> single-cycle trig_err, echo stays 0, block back in IDLE.
REQ-035 d=0 -> echo 5800 clocks; d=400 -> 2320000 clocks; d=401 and d=511 -> 3800000 clocks.
REQ-036 Second trig pulse during ECHO and during HOLDOFF -> ignored, no trig_err; next trig after IDLE is served normally.
REQ-037 enable=0 with a trig pulse -> busy stays 0; enable dropped during BURST -> full echo and holdoff still produced.
REQ-038 Reset pulse in mid-ECHO -> echo=0 and busy=0 immediately; trig held high through release -> no response until a fresh rising edge.
